paddle_ctrl: RTL and testbench

// - Producer side of the paddle interface that ball consumes (Paddle1X/Y/L/W, Paddle2X/Y/L/W).
// - Decodes the USB keycode into up/down commands for the left paddle (P1) and right paddle (P2),

---
 rtl/paddle_ctrl_pkg.sv | 47 ++++
 rtl/paddle_ctrl_axis.sv | 95 +++++++++
 rtl/paddle_ctrl.sv | 81 ++++++++
 tb/tb_paddle_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/paddle_ctrl_pkg.sv
// Shared paddle constants, key codes, FSM state type and the playfield clamp helper.
// Pure definitions: no latency, no flow control.
package paddle_ctrl_pkg;

    localparam logic [9:0] P1_X        = 10'd40;
    localparam logic [9:0] P2_X        = 10'd590;
    localparam logic [9:0] PAD_L       = 10'd24;
    localparam logic [9:0] PAD_W       = 10'd4;
    localparam logic [9:0] Y_MIN       = 10'd20;
    localparam logic [9:0] Y_MAX       = 10'd461;
    localparam logic [9:0] Y_CENTER    = 10'd240;
    localparam logic [9:0] AI_DEADBAND = 10'd4;

    localparam logic [3:0] MIN_STEP     = 4'd2;
    localparam logic [3:0] MAX_STEP     = 4'd8;
    localparam logic [3:0] ACCEL_FRAMES = 4'd8;
    localparam logic [3:0] AI_STEP      = 4'd3;

    localparam logic [7:0] KEY_P1_UP = 8'h1A;
    localparam logic [7:0] KEY_P1_DN = 8'h16;
    localparam logic [7:0] KEY_P2_UP = 8'h52;
    localparam logic [7:0] KEY_P2_DN = 8'h51;

    // Paddle centre travel limits so the paddle body never leaves the playfield.
    localparam logic signed [10:0] Y_LO  = $signed({1'b0, Y_MIN}) + $signed({1'b0, PAD_L});
    localparam logic signed [10:0] Y_HI  = $signed({1'b0, Y_MAX}) - $signed({1'b0, PAD_L});
    localparam logic signed [10:0] AI_DB = $signed({1'b0, AI_DEADBAND});

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DN
    } paddle_state_t;

    function automatic logic [9:0] clamp_y(input logic signed [10:0] y);
        logic [9:0] r;
        if (y < Y_LO) begin
            r = Y_LO[9:0];
        end else if (y > Y_HI) begin
            r = Y_HI[9:0];
        end else begin
            r = y[9:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/paddle_ctrl_axis.sv
// One paddle's vertical axis: IDLE/MOVE_UP/MOVE_DN FSM, hold-to-accelerate ramp, clamped Y register.
// Command at a frame edge shows on y_o after that edge; recentre overrides any command.
module paddle_ctrl_axis
    import paddle_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       up_i,
    input  logic       dn_i,
    input  logic       recentre_i,
    input  logic [3:0] max_step_i,
    input  logic       step_ovr_en_i,
    input  logic [3:0] step_ovr_i,
    output logic [9:0] y_o
);

    paddle_state_t     state_q, state_d, want;
    logic [3:0]        speed_q, speed_d;
    logic [3:0]        cnt_q, cnt_d, cnt_inc;
    logic [3:0]        step;
    logic [9:0]        y_q, y_d;
    logic signed [10:0] y_next;

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        step    = '0;
        cnt_inc = cnt_q + 4'd1;
        y_next  = '0;
        want    = IDLE;

        if (up_i && !dn_i) begin
            want = MOVE_UP;
        end else if (dn_i && !up_i) begin
            want = MOVE_DN;
        end

        if (recentre_i) begin
            state_d = IDLE;
            speed_d = MIN_STEP;
            cnt_d   = '0;
            y_d     = Y_CENTER;
        end else if (want == IDLE) begin
            state_d = IDLE;
            speed_d = MIN_STEP;
            cnt_d   = '0;
        end else begin
            if (state_q == want) begin
                // Move at the speed already earned; the ramp applies from the next frame.
                step = speed_q;
                if (cnt_inc == ACCEL_FRAMES) begin
                    speed_d = (speed_q >= max_step_i) ? max_step_i : speed_q + 4'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else begin
                state_d = want;
                speed_d = MIN_STEP;
                cnt_d   = 4'd1;
                step    = MIN_STEP;
            end

            if (step_ovr_en_i) begin
                step = step_ovr_i;
            end

            if (want == MOVE_UP) begin
                y_next = $signed({1'b0, y_q}) - $signed({7'b0, step});
            end else begin
                y_next = $signed({1'b0, y_q}) + $signed({7'b0, step});
            end
            y_d = clamp_y(y_next);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            speed_q <= MIN_STEP;
            cnt_q   <= '0;
            y_q     <= Y_CENTER;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle producer for ball: keycode decode, optional AI tracking for P2, constant X/L/W extents.
// Paddle Y updates one frame_clk edge after the command; no backpressure, resetB recentres both.
module paddle_ctrl
    import paddle_ctrl_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic       AI_en,
    input  logic [9:0] BallY,
    input  logic       resetB,
    output logic [9:0] Paddle1X,
    output logic [9:0] Paddle1Y,
    output logic [9:0] Paddle2X,
    output logic [9:0] Paddle2Y,
    output logic [9:0] Paddle1L,
    output logic [9:0] Paddle1W,
    output logic [9:0] Paddle2L,
    output logic [9:0] Paddle2W
);

    logic              p1_up, p1_dn, p2_up, p2_dn;
    logic              ai_up, ai_dn;
    logic signed [10:0] ai_diff, ai_mag;
    logic [10:0]       ai_excess;
    logic [3:0]        ai_step;
    logic [9:0]        p1_y, p2_y;

    assign p1_up = (keycode == KEY_P1_UP);
    assign p1_dn = (keycode == KEY_P1_DN);

    // AI steps only as far as the deadband edge so it settles inside it instead of hunting.
    always_comb begin
        ai_diff   = $signed({1'b0, BallY}) - $signed({1'b0, p2_y});
        ai_up     = (ai_diff < -AI_DB);
        ai_dn     = (ai_diff > AI_DB);
        ai_mag    = ai_up ? -ai_diff : ai_diff;
        ai_excess = '0;
        if (ai_up || ai_dn) begin
            ai_excess = ai_mag - AI_DB;
        end
        ai_step = (ai_excess > {7'b0, AI_STEP}) ? AI_STEP : ai_excess[3:0];
    end

    assign p2_up = AI_en ? ai_up : (keycode == KEY_P2_UP);
    assign p2_dn = AI_en ? ai_dn : (keycode == KEY_P2_DN);

    paddle_ctrl_axis u_p1 (
        .clk_i         (frame_clk),
        .rst_ni        (Reset_n),
        .up_i          (p1_up),
        .dn_i          (p1_dn),
        .recentre_i    (resetB),
        .max_step_i    (MAX_STEP),
        .step_ovr_en_i (1'b0),
        .step_ovr_i    (4'd0),
        .y_o           (p1_y)
    );

    paddle_ctrl_axis u_p2 (
        .clk_i         (frame_clk),
        .rst_ni        (Reset_n),
        .up_i          (p2_up),
        .dn_i          (p2_dn),
        .recentre_i    (resetB),
        .max_step_i    (MAX_STEP),
        .step_ovr_en_i (AI_en),
        .step_ovr_i    (ai_step),
        .y_o           (p2_y)
    );

    assign Paddle1X = P1_X;
    assign Paddle2X = P2_X;
    assign Paddle1Y = p1_y;
    assign Paddle2Y = p2_y;
    assign Paddle1L = PAD_L;
    assign Paddle2L = PAD_L;
    assign Paddle1W = PAD_W;
    assign Paddle2W = PAD_W;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed scenarios plus randomized key/AI/recentre traffic against an integer paddle model.
module tb_paddle_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset_n   = 1'b0;
    logic [7:0] keycode   = 8'h00;
    logic       AI_en     = 1'b0;
    logic [9:0] BallY     = 10'd0;
    logic       resetB    = 1'b0;
    logic [9:0] Paddle1X, Paddle1Y, Paddle2X, Paddle2Y;
    logic [9:0] Paddle1L, Paddle1W, Paddle2L, Paddle2W;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per paddle: y, direction (-1 up, +1 down, 0 idle), speed, hold count.
    int my[2], mdir[2], mspd[2], mcnt[2];

    paddle_ctrl dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycode   (keycode),
        .AI_en     (AI_en),
        .BallY     (BallY),
        .resetB    (resetB),
        .Paddle1X  (Paddle1X),
        .Paddle1Y  (Paddle1Y),
        .Paddle2X  (Paddle2X),
        .Paddle2Y  (Paddle2Y),
        .Paddle1L  (Paddle1L),
        .Paddle1W  (Paddle1W),
        .Paddle2L  (Paddle2L),
        .Paddle2W  (Paddle2W)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int clampy(input int y);
        if (y < 44) return 44;
        if (y > 437) return 437;
        return y;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            my[p] = 240; mdir[p] = 0; mspd[p] = 2; mcnt[p] = 0;
        end
    endtask

    task automatic model_axis(input int p, input int cmd, input int ovr);
        int mv;
        mv = 0;
        if (cmd == 0) begin
            mdir[p] = 0; mspd[p] = 2; mcnt[p] = 0;
        end else if (cmd == mdir[p]) begin
            mv = mspd[p];
            mcnt[p]++;
            if (mcnt[p] == 8) begin
                mspd[p] = (mspd[p] + 1 > 8) ? 8 : mspd[p] + 1;
                mcnt[p] = 0;
            end
        end else begin
            mdir[p] = cmd; mspd[p] = 2; mcnt[p] = 1; mv = 2;
        end
        if (ovr >= 0) mv = ovr;
        my[p] = clampy(my[p] + cmd * mv);
    endtask

    task automatic model_edge();
        int c1, c2, d, st;
        if (!Reset_n || resetB) begin
            model_reset();
        end else begin
            c1 = (keycode == 8'h1A) ? -1 : (keycode == 8'h16) ? 1 : 0;
            st = -1;
            if (AI_en) begin
                d = int'(BallY) - my[1];
                if (d < -4) begin
                    c2 = -1; st = (-d - 4 > 3) ? 3 : -d - 4;
                end else if (d > 4) begin
                    c2 = 1;  st = (d - 4 > 3) ? 3 : d - 4;
                end else begin
                    c2 = 0;
                end
            end else begin
                c2 = (keycode == 8'h52) ? -1 : (keycode == 8'h51) ? 1 : 0;
            end
            model_axis(0, c1, -1);
            model_axis(1, c2, st);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".p1y"}, Paddle1Y, my[0]);
        chk({tag, ".p2y"}, Paddle2Y, my[1]);
        chk({tag, ".p1x"}, Paddle1X, 40);
        chk({tag, ".p2x"}, Paddle2X, 590);
        chk({tag, ".l"},   {Paddle1L, Paddle2L}, {10'd24, 10'd24});
        chk({tag, ".w"},   {Paddle1W, Paddle2W}, {10'd4, 10'd4});
    endtask

    // Inputs are stable from the previous negedge; update the model at the edge, check at negedge.
    task automatic tick(input string tag);
        @(posedge frame_clk);
        model_edge();
        @(negedge frame_clk);
        check_all(tag);
    endtask

    initial begin
        logic [7:0] keys [7];
        int hold, y_before;
        keys = '{8'h00, 8'h1A, 8'h16, 8'h52, 8'h51, 8'h04, 8'hFF};

        #12;
        model_reset();
        check_all("reset");
        Reset_n = 1'b1;

        keycode = 8'h1A;
        repeat (10) tick("w_hold");
        chk("w10_p1y", Paddle1Y, 218);
        chk("w10_p2y", Paddle2Y, 240);
        keycode = 8'h00;
        tick("w_rel");

        resetB = 1'b1; tick("rb"); resetB = 1'b0;
        keycode = 8'h51;
        repeat (200) begin
            tick("dn_hold");
            if (Paddle2Y > 10'd437) chk("dn_over", Paddle2Y, 437);
        end
        chk("dn_sat", Paddle2Y, 437);
        keycode = 8'h00;
        repeat (3) tick("dn_rel");
        chk("dn_hold437", Paddle2Y, 437);

        resetB = 1'b1; tick("rb"); resetB = 1'b0;
        keycode = 8'h16;
        repeat (12) tick("s_hold");
        y_before = int'(Paddle1Y);
        keycode = 8'h1A;
        tick("rev");
        chk("rev_step", y_before - int'(Paddle1Y), 2);

        keycode = 8'h00;
        resetB = 1'b1; tick("rb"); resetB = 1'b0;
        AI_en = 1'b1; BallY = 10'd100; keycode = 8'h52;
        repeat (60) tick("ai");
        chk("ai_stop", Paddle2Y, 104);
        AI_en = 1'b0; keycode = 8'h00;

        resetB = 1'b1; tick("rb"); resetB = 1'b0;
        keycode = 8'h1A;
        repeat (4) tick("rb_hold");
        resetB = 1'b1;
        tick("rb_pulse");
        chk("rb_p1y", Paddle1Y, 240);
        chk("rb_p2y", Paddle2Y, 240);
        resetB = 1'b0;
        tick("rb_after");
        chk("rb_next", Paddle1Y, 238);

        keycode = 8'h16;
        repeat (20) tick("arst_hold");
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        tick("arst_low");
        Reset_n = 1'b1;
        tick("arst_rel");
        chk("arst_step", Paddle1Y, 242);

        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                keycode = keys[$urandom_range(0, 6)];
                hold = $urandom_range(1, 40);
            end
            hold--;
            if ($urandom_range(0, 149) == 0) AI_en = ~AI_en;
            if ($urandom_range(0, 29) == 0) BallY = 10'($urandom_range(0, 500));
            resetB = ($urandom_range(0, 99) == 0);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
